// File: rtl/jj_pkg.sv
// Shared game geometry: wall-map dimensions, sprite size and coordinate widths.
package jj_pkg;

  localparam int unsigned MAP_W  = 160;
  localparam int unsigned MAP_H  = 120;
  localparam int unsigned DUDE_W = 4;
  localparam int unsigned DUDE_H = 4;
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;

  // One bit wider than the coordinates so bound sums never wrap.
  localparam int unsigned XE_W   = X_W + 1;
  localparam int unsigned YE_W   = Y_W + 1;
  // Row counter within the sprite.
  localparam int unsigned ROW_W  = (DUDE_H > 1) ? $clog2(DUDE_H) : 1;

  // Sprite position latched for the duration of one check.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } coord_t;

endpackage

// File: rtl/collision_reader.sv
// Reads the wall-map rows under the sprite and reports wall overlap or out-of-bounds.
module collision_reader
  import jj_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [X_W-1:0]   dude_x,
  input  logic [Y_W-1:0]   dude_y,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic             oob,
  output logic             ram_rd_en,
  output logic [Y_W-1:0]   ram_addr,
  input  logic [MAP_W-1:0] ram_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  coord_t           pos_q, pos_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hit_q, hit_d;
  logic             oob_q, oob_d;
  logic             rd_en_q, rd_en_d;
  logic [Y_W-1:0]   addr_q, addr_d;
  logic             rd_vld_q, rd_vld_d;

  logic             oob_c;
  logic             win_hit_c;

  // Bounds test on the incoming coordinates, evaluated one bit wide so it cannot wrap.
  assign oob_c = (({1'b0, dude_x} + XE_W'(DUDE_W)) > XE_W'(MAP_W)) ||
                 (({1'b0, dude_y} + YE_W'(DUDE_H)) > YE_W'(MAP_H));

  // Any wall pixel inside the sprite's column window of the returned row.
  assign win_hit_c = |ram_rdata[pos_q.x +: DUDE_W];

  // Next state, latched coordinates and registered outputs.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    row_d    = row_q;
    hit_d    = hit_q;
    oob_d    = oob_q;
    addr_d   = addr_q;
    done_d   = (state_q == S_DONE);
    rd_en_d  = (state_q == S_READ);
    rd_vld_d = rd_en_q;

    // Row data returns one cycle after the strobe; fold it into the sticky hit.
    if (rd_vld_q && win_hit_c) begin
      hit_d = 1'b1;
    end

    if (state_q == S_READ) begin
      addr_d = Y_W'(pos_q.y + Y_W'(row_q));
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pos_d.x = dude_x;
          pos_d.y = dude_y;
          row_d   = '0;
          hit_d   = 1'b0;
          oob_d   = 1'b0;
          if (oob_c) begin
            hit_d   = 1'b1;
            oob_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (row_q == ROW_W'(DUDE_H - 1)) begin
          state_d = S_DRAIN;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pos_q    <= '0;
      row_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
      oob_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      row_q    <= row_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hit_q    <= hit_d;
      oob_q    <= oob_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hit       = hit_q;
  assign oob       = oob_q;
  assign ram_rd_en = rd_en_q;
  assign ram_addr  = addr_q;

endmodule

// File: tb/tb_collision_reader.sv
// Scoreboard bench for collision_reader with a 1-cycle-latency wall-map RAM model.
module tb_collision_reader;
  import jj_pkg::*;

  logic             clk = 1'b0;
  logic             resetn;
  logic             start;
  logic [X_W-1:0]   dude_x;
  logic [Y_W-1:0]   dude_y;
  logic             busy, done, hit, oob, ram_rd_en;
  logic [Y_W-1:0]   ram_addr;
  logic [MAP_W-1:0] ram_rdata;

  logic [MAP_W-1:0] mem [MAP_H];

  typedef struct packed {
    int   s;
    int   y;
    logic hit;
    logic oob;
  } exp_t;

  exp_t exp_q[$];
  int   rd_addr_log[$];
  int   rd_cyc_log[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  collision_reader dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .dude_x    (dude_x),
    .dude_y    (dude_y),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .oob       (oob),
    .ram_rd_en (ram_rd_en),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data only meaningful the cycle after a strobe, garbage otherwise.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
    else           ram_rdata <= '1;
  end

  function automatic logic model_oob(input int x, input int y);
    return (x + int'(DUDE_W) > int'(MAP_W)) || (y + int'(DUDE_H) > int'(MAP_H));
  endfunction

  function automatic logic model_hit(input int x, input int y);
    if (model_oob(x, y)) return 1'b1;
    for (int r = y; r < y + int'(DUDE_H); r++)
      for (int c = x; c < x + int'(DUDE_W); c++)
        if (mem[r][c]) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: log reads, and on every done pop the scoreboard and compare.
  always @(negedge clk) begin
    if (ram_rd_en === 1'b1) begin
      rd_addr_log.push_back(int'(ram_addr));
      rd_cyc_log.push_back(cyc);
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
      end else begin
        exp_t e;
        int   lat;
        int   nrd;
        logic seq_ok;
        e   = exp_q.pop_front();
        lat = e.oob ? 1 : int'(DUDE_H) + 2;
        nrd = e.oob ? 0 : int'(DUDE_H);
        checks++;
        if (hit !== e.hit) begin
          errors++;
          $display("FAIL hit: got %b, required %b (y=%0d)", hit, e.hit, e.y);
        end
        checks++;
        if (oob !== e.oob) begin
          errors++;
          $display("FAIL oob: got %b, required %b (y=%0d)", oob, e.oob, e.y);
        end
        checks++;
        if (cyc !== e.s + lat) begin
          errors++;
          $display("FAIL latency: done at %0d edges after start, required %0d", cyc - e.s, lat);
        end
        checks++;
        if (rd_addr_log.size() != nrd) begin
          errors++;
          $display("FAIL read_count: got %0d reads, required %0d", rd_addr_log.size(), nrd);
        end else begin
          seq_ok = 1'b1;
          for (int i = 0; i < nrd; i++)
            if (rd_addr_log[i] != e.y + i || rd_cyc_log[i] != e.s + 1 + i) seq_ok = 1'b0;
          checks++;
          if (!seq_ok) begin
            errors++;
            $display("FAIL read_seq: first addr %0d at edge +%0d, required rows %0d.. consecutive from edge +1",
                     (nrd > 0) ? rd_addr_log[0] : -1, (nrd > 0) ? rd_cyc_log[0] - e.s : -1, e.y);
          end
        end
      end
      rd_addr_log.delete();
      rd_cyc_log.delete();
    end
  end

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push_exp(input int x, input int y, input int s);
    exp_t e;
    e.s   = s;
    e.y   = y;
    e.hit = model_hit(x, y);
    e.oob = model_oob(x, y);
    exp_q.push_back(e);
  endtask

  task automatic run_check(input int x, input int y);
    @(negedge clk);
    dude_x = X_W'(x);
    dude_y = Y_W'(y);
    start  = 1'b1;
    push_exp(x, y, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b, required 1", busy);
    end
    wait_empty();
  endtask

  task automatic clear_map();
    for (int r = 0; r < int'(MAP_H); r++) mem[r] = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b0;
    dude_x = '0;
    dude_y = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, hit, oob, ram_rd_en} !== 5'b0 || ram_addr !== '0) begin
      errors++;
      $display("FAIL reset_values: busy/done/hit/oob/rd_en=%b addr=%0d, required 00000 addr=0",
               {busy, done, hit, oob, ram_rd_en}, ram_addr);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_empty_map();
    clear_map();
    run_check(20, 10);
  endtask

  task automatic test_window();
    clear_map();
    mem[12][23] = 1'b1;
    mem[13][28] = 1'b1;
    run_check(20, 10);
    run_check(24, 10);
    run_check(25, 9);
  endtask

  task automatic test_boundary();
    clear_map();
    mem[119][159] = 1'b1;
    run_check(156, 116);
    run_check(156, 112);
    run_check(157, 116);
    run_check(156, 117);
    run_check(253, 0);
    run_check(0, 127);
  endtask

  task automatic test_back_to_back();
    clear_map();
    @(negedge clk);
    dude_x = X_W'(40);
    dude_y = Y_W'(50);
    start  = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(40, 50, cyc + 1 + k * (int'(DUDE_H) + 3));
    @(negedge clk);
    checks++;
    if (hit !== 1'b0 || oob !== 1'b0) begin
      errors++;
      $display("FAIL hit_clear_on_start: hit=%b oob=%b, required 0 0", hit, oob);
    end
    repeat (2 * (int'(DUDE_H) + 3)) @(negedge clk);
    start = 1'b0;
    wait_empty();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    clear_map();
    mem[12][23] = 1'b1;
    @(negedge clk);
    dude_x = X_W'(20);
    dude_y = Y_W'(10);
    start  = 1'b1;
    push_exp(20, 10, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dude_x = X_W'(24);
    dude_y = Y_W'(100);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_check();
    clear_map();
    mem[10][21] = 1'b1;
    @(negedge clk);
    dude_x = X_W'(20);
    dude_y = Y_W'(10);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ram_rd_en !== 1'b1 || ram_addr !== Y_W'(11)) begin
      errors++;
      $display("FAIL second_read: rd_en=%b addr=%0d, required 1 11", ram_rd_en, ram_addr);
    end
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ram_rd_en !== 1'b0 || hit !== 1'b0 || done !== 1'b0 || oob !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b rd_en=%b hit=%b done=%b oob=%b, required all 0",
               busy, ram_rd_en, hit, done, oob);
    end
    resetn = 1'b1;
    rd_addr_log.delete();
    rd_cyc_log.delete();
    repeat (10) @(negedge clk);
    run_check(20, 10);
  endtask

  initial begin
    for (int r = 0; r < int'(MAP_H); r++) mem[r] = '0;
    test_reset();
    test_empty_map();
    test_window();
    test_boundary();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
